// File: rtl/seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// seq_divider_pkg
//   Shared definitions for the multi-cycle signed divider and the downstream
//   result-select multiplexer.
//   - DATA_WIDTH : datapath width shared by the divider and the result mux
//   - div_state_t: divider FSM state encoding
// ---------------------------------------------------------------------------
package seq_divider_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_magnitude_core.sv
// ---------------------------------------------------------------------------
// div_magnitude_core
//   Unsigned restoring-division datapath. Produces one quotient bit per
//   clock while 'step' is high. The caller is responsible for signs.
//
//   Ports:
//     clock        : rising-edge clock
//     clear        : asynchronous active-low reset
//     load         : capture magnitudes and restart the iteration counter
//     step         : perform one restoring iteration
//     dividend_mag : unsigned dividend magnitude (sampled on load)
//     divisor_mag  : unsigned divisor magnitude (sampled on load)
//     q_mag        : unsigned quotient magnitude (valid after WIDTH steps)
//     r_mag        : unsigned remainder magnitude (valid after WIDTH steps)
//     last         : iteration counter is zero (final step in progress)
// ---------------------------------------------------------------------------
module div_magnitude_core
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend_mag,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] q_mag,
  output logic [WIDTH-1:0] r_mag,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dsor;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] shifted_rem;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder. The partial
  // remainder is always below the divisor magnitude, and signed operand
  // magnitudes never exceed 2^(WIDTH-1), so its top bit is always zero and
  // the shifted value fits in WIDTH bits. The trial subtraction is one bit
  // wider so its MSB is a clean borrow flag.
  always_comb begin
    shifted_rem = {prem[WIDTH-2:0], shreg[WIDTH-1]};
    trial       = {1'b0, shifted_rem} - {1'b0, dsor};
  end

  // The shift register starts holding the dividend magnitude and, as its
  // bits move into the partial remainder, fills from the bottom with the
  // quotient bits. After WIDTH steps it holds the full quotient magnitude.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      prem  <= '0;
      shreg <= '0;
      dsor  <= '0;
      count <= '0;
    end else if (load) begin
      prem  <= '0;
      shreg <= dividend_mag;
      dsor  <= divisor_mag;
      count <= CW'(WIDTH - 1);
    end else if (step) begin
      if (!trial[WIDTH]) begin
        prem <= trial[WIDTH-1:0];
      end else begin
        prem <= shifted_rem;
      end
      shreg <= {shreg[WIDTH-2:0], ~trial[WIDTH]};
      count <= count - CW'(1);
    end
  end

  assign q_mag = shreg;
  assign r_mag = prem;
  assign last  = (count == '0);

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Multi-cycle signed integer divider. A one-cycle start pulse in IDLE
//   captures the operands; the quotient (truncated toward zero) and the
//   remainder (sign of the dividend) appear WIDTH+2 edges later, flagged by
//   a one-cycle done pulse. Division by zero finishes on the next cycle with
//   div_by_zero set, quotient 0 and remainder equal to the dividend.
//
//   Ports:
//     clock       : rising-edge clock
//     clear       : asynchronous active-low reset
//     start       : one-cycle request, only honoured in IDLE
//     dividend    : signed dividend, captured on the accepting edge
//     divisor     : signed divisor, captured on the accepting edge
//     busy        : high in every state except IDLE
//     done        : one-cycle pulse when results become valid
//     div_by_zero : set with done for a zero divisor, held until next accept
//     quotient    : registered signed quotient
//     remainder   : registered signed remainder
// ---------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t state;
  div_state_t next_state;

  logic             accept;
  logic             divisor_zero;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic             core_load;
  logic             core_step;
  logic             core_last;

  // Operand magnitudes are plain WIDTH-bit unsigned values; the most
  // negative number negates to itself, which read as unsigned is exactly
  // its magnitude.
  always_comb begin
    accept       = start && (state == IDLE);
    divisor_zero = (divisor == '0);
    dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    core_load    = accept && !divisor_zero;
    core_step    = (state == CALC);
  end

  div_magnitude_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock       (clock),
    .clear       (clear),
    .load        (core_load),
    .step        (core_step),
    .dividend_mag(dividend_mag),
    .divisor_mag (divisor_mag),
    .q_mag       (q_mag),
    .r_mag       (r_mag),
    .last        (core_last)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The core counter reaches zero on the last of the
  // WIDTH iterations, so CALC is left on that same edge.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next_state = divisor_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (core_last) begin
          next_state = FIXUP;
        end
      end
      FIXUP: next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs decoded straight from the state register.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Result registers. They hold across IDLE so the result mux can keep
  // reading them until the next division overwrites them.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else if (accept) begin
      sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r      <= dividend[WIDTH-1];
      div_by_zero <= divisor_zero;
      if (divisor_zero) begin
        quotient  <= '0;
        remainder <= dividend;
      end
    end else if (state == FIXUP) begin
      quotient  <= sign_q ? -q_mag : q_mag;
      remainder <= sign_r ? -r_mag : r_mag;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Scoreboard bench for seq_divider: directed operand pairs push their
//   hand-computed results into a queue; a monitor pops and compares on done.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int checks;
  int passed;
  int busy_cnt;
  bit check_idle;

  seq_divider #(
    .WIDTH(32)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison with pass/fail bookkeeping.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: counts cycles busy has been high, checks each done against the
  // scoreboard head and checks the cycle after done is back in IDLE.
  always @(negedge clock) begin
    exp_t e;
    if (busy) busy_cnt++;
    else      busy_cnt = 0;
    if (check_idle) begin
      checkOutput("idle_after_done", {30'd0, busy, done}, 32'd0);
      check_idle = 1'b0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no result pending");
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        checkOutput("latency", busy_cnt, e.lat);
      end
      check_idle = 1'b1;
    end
  end

  // Issue one division and record its expected result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eq, input logic [31:0] er,
                               input logic edbz, input int lat);
    exp_t e;
    @(negedge clock);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.q = eq; e.r = er; e.dbz = edbz; e.lat = lat;
    sb.push_back(e);
    @(negedge clock);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Bounded wait for the scoreboard to drain.
  task automatic waitDone();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    checks     = 0;
    passed     = 0;
    busy_cnt   = 0;
    check_idle = 1'b0;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    clear      = 1'b1;
    #3 clear = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    clear = 1'b1;

    // Signed cases, full 34-edge latency.
    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    waitDone();
    applyStimulus(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    waitDone();
    applyStimulus(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
    waitDone();
    applyStimulus(-32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 1'b0, 34);
    waitDone();
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
    waitDone();
    applyStimulus(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 34);
    waitDone();

    // Divide by zero finishes one cycle after accept.
    applyStimulus(32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1);
    waitDone();

    // A start pulse while busy must be ignored.
    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    repeat (8) @(negedge clock);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(negedge clock);
    start    = 1'b0;
    waitDone();

    // Give the held results a nonzero value before aborting a run.
    applyStimulus(32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1);
    waitDone();
    @(negedge clock);
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(negedge clock);
    start    = 1'b0;
    repeat (19) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    checkOutput("abort_quotient", quotient, 32'd0);
    checkOutput("abort_remainder", remainder, 32'd0);
    @(negedge clock);
    clear = 1'b1;

    applyStimulus(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);
    waitDone();

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed integer divider in the datapath's ALU cluster.
- Produces the 32-bit quotient (LO) and remainder (HI) results.
- Its registered outputs drive data inputs of the downstream 3:1 result-select multiplexer, which places ALU, quotient or remainder onto the result path.
- Control unit starts it with a one-cycle pulse and stalls until done.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >= 4)

Ports:
- clock  input  1  system clock, rising-edge active
- clear  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a division; sampled only in IDLE
- dividend  input  WIDTH  signed dividend, captured on the accepting edge
- divisor  input  WIDTH  signed divisor, captured on the accepting edge
- busy  output  1  high from the accepting edge until DONE is left
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle onward
- div_by_zero  output  1  set with done when divisor was 0; held until the next accept
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder, same sign as dividend (or zero)

Behaviour:
- One clock. Reset is asynchronous and active-low on clear.
- Reset (clear=0) forces:
  - state = IDLE
  - busy = done = div_by_zero = 0
  - quotient = remainder = 0
  - iteration counter = 0
  - Reset has effect immediately, independent of clock, including mid-operation; the partial result is discarded.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - start=1 at edge E0 captures the operands and records sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
  - Magnitudes are loaded as unsigned WIDTH-bit values. |0x80000000| = 0x80000000 unsigned, no extra bit.
  - divisor==0 → DONE directly, with div_by_zero=1, quotient=0, remainder=dividend.
  - Otherwise → CALC with counter=WIDTH-1.
- CALC: restoring division, one quotient bit per edge.
  - Shift {partial_rem, dividend_mag} left by 1.
  - trial = partial_rem - divisor_mag, computed WIDTH+1 bits wide.
  - trial non-negative → partial_rem = trial and quotient bit = 1; else quotient bit = 0.
  - counter decrements each edge. At counter==0 → FIXUP. CALC lasts exactly WIDTH edges.
- FIXUP:
  - quotient = sign_q ? -q_mag : q_mag; remainder = sign_r ? -r_mag : r_mag, both two's-complement modulo 2^WIDTH.
  - → DONE.
- DONE: done=1 for exactly one cycle, busy=1. → IDLE on the next edge.
- Latency: start accepted at E0 → done high in the cycle after edge E0+WIDTH+1 (34 edges for WIDTH=32). Divide-by-zero: done in the cycle after E0.
- busy=1 in CALC, FIXUP and DONE; busy=0 only in IDLE.
- start while busy is ignored (no queueing); operand inputs are don't-care after E0.
- quotient/remainder hold their last values across IDLE until the next FIXUP (or divide-by-zero DONE) overwrites them.
- Overflow case: 0x80000000 / -1 gives quotient 0x80000000 (wraps), remainder 0, div_by_zero=0.
- Zero dividend: quotient 0, remainder 0, full latency.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, CALC=2'd1, FIXUP=2'd2, DONE=2'd3)
  - DATA_WIDTH=32 constant used by the divider and the result-select mux
- Natural sub-module: div_magnitude_core, containing the unsigned restoring-iteration datapath (partial remainder, shift register, counter).
- Sign handling and the FSM stay in seq_divider.

Test Plan:
- Basic divide: 100 / 7, pulse start → done after 34 edges; quotient=14, remainder=2, div_by_zero=0, busy low next cycle.
- Negative dividend: -100 / 7 → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
- Negative divisor: 100 / -7 → quotient=0xFFFFFFF2, remainder=2.
- Overflow: 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divide by zero: 5 / 0 → done one cycle after accept; div_by_zero=1, quotient=0, remainder=5.
- Control edge cases:
  - Re-pulse start with different operands at cycle 10 of a running 100/7 → ignored; result is still 14/2.
  - Drive clear low at cycle 20 of a run → outputs 0 and state IDLE immediately.
  - A subsequent 9/3 → quotient=3, remainder=0.
